stress_load_gen: RTL and testbench

- Parametrised successor to the single-chain flip-flop drainer: N independent LFSR+adder lanes generating controllable switching load, for studying supply noise against the HDMI path.
- Replaces cascaded CLKDIV primitives with a programmable clock-enable prescaler.
- Adds lane masking plus continuous, burst and sweep load modes.
- Result is XOR-reduced to one bit (LED) so synthesis keeps every lane.

---
 rtl/stress_pkg.sv | 29 ++
 rtl/stress_lane.sv | 32 +++
 rtl/stress_load_gen.sv | 166 ++++++++++++++++
 tb/tb_stress_load_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stress_pkg.sv
// Shared types and LFSR tap table for the stress load generator.
package stress_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_CONT  = 2'd1,
        MODE_BURST = 2'd2,
        MODE_SWEEP = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_B_ON,
        ST_B_OFF,
        ST_SWEEP
    } state_t;

    // Maximal-length Galois taps for the supported lane widths.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_A300_0000;
            default: return 64'hD800_0000_0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/stress_lane.sv
// One load lane: a Galois LFSR feeding a wrapping accumulator, advanced on step.
module stress_lane
    import stress_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] acc
);

    localparam logic [63:0]  TAPS64 = lfsr_taps(W);
    localparam logic [W-1:0] TAPS   = TAPS64[W-1:0];

    logic [W-1:0] r_lfsr;
    logic [W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= seed;
            r_acc  <= '0;
        end else if (step) begin
            r_acc  <= r_acc + r_lfsr;
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/stress_load_gen.sv
// Multi-lane switching-load generator: mode FSM, clock-enable prescaler,
// burst/sweep timing and an XOR fold of every accumulator onto one pin.
module stress_load_gen
    import stress_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int LANE_WIDTH  = 32,
    parameter int DIV_WIDTH   = 24,
    parameter int BURST_WIDTH = 16,
    parameter int SEED_BASE   = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [DIV_WIDTH-1:0]         div_sel,
    input  logic [BURST_WIDTH-1:0]       burst_on,
    input  logic [BURST_WIDTH-1:0]       burst_off,
    input  logic [LANES-1:0]             lane_mask,
    output logic                         out,
    output logic                         active,
    output logic [$clog2(LANES+1)-1:0]   level
);

    localparam int               LVL_W    = $clog2(LANES + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(LANES);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    state_t                 r_state, w_state_nxt;
    logic [LVL_W-1:0]       r_level, w_level_nxt;
    logic [BURST_WIDTH-1:0] r_bcnt, w_bcnt_nxt;
    logic [DIV_WIDTH-1:0]   r_pcnt;
    logic                   r_active, r_out;
    logic                   w_active_nxt, w_exit, w_tick, w_pclr, w_xor;
    mode_t                  w_mode, w_state_mode;
    logic [LANES-1:0]       w_step;
    logic [LANE_WIDTH-1:0]  w_acc [LANES];

    assign w_mode = mode_t'(mode);

    // Each running state belongs to one mode; any disagreement forces a pass through IDLE.
    always_comb begin
        w_state_mode = MODE_OFF;
        case (r_state)
            ST_RUN:             w_state_mode = MODE_CONT;
            ST_B_ON, ST_B_OFF:  w_state_mode = MODE_BURST;
            ST_SWEEP:           w_state_mode = MODE_SWEEP;
            default:            w_state_mode = MODE_OFF;
        endcase
    end

    assign w_exit = (r_state != ST_IDLE) && (!enable || (w_mode != w_state_mode));

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_bcnt_nxt  = r_bcnt;
        if (w_exit) begin
            w_state_nxt = ST_IDLE;
            w_level_nxt = '0;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        case (w_mode)
                            MODE_CONT:  begin w_state_nxt = ST_RUN;   w_level_nxt = LVL_FULL; end
                            MODE_BURST: begin w_state_nxt = ST_B_ON;  w_level_nxt = LVL_FULL; end
                            MODE_SWEEP: begin w_state_nxt = ST_SWEEP; w_level_nxt = LVL_ONE;  end
                            default:    w_state_nxt = ST_IDLE;
                        endcase
                    end
                end
                ST_B_ON: begin
                    if (r_bcnt == burst_on) begin
                        w_state_nxt = ST_B_OFF;
                        w_level_nxt = '0;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + BURST_WIDTH'(1);
                    end
                end
                ST_B_OFF: begin
                    if (r_bcnt == burst_off) begin
                        w_state_nxt = ST_B_ON;
                        w_level_nxt = LVL_FULL;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + BURST_WIDTH'(1);
                    end
                end
                ST_SWEEP: begin
                    if (r_bcnt == burst_on) begin
                        w_level_nxt = (r_level == LVL_FULL) ? LVL_ONE : r_level + LVL_W'(1);
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + BURST_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_active_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_B_ON) ||
                          (w_state_nxt == ST_SWEEP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_level  <= '0;
            r_bcnt   <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_level  <= w_level_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Clearing on both sides of IDLE/B_OFF makes every ON segment start from count 0.
    assign w_tick = (r_pcnt == div_sel);
    assign w_pclr = (r_state == ST_IDLE) || (r_state == ST_B_OFF) ||
                    (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_B_OFF);

    always_ff @(posedge clk) begin
        if (!resetn || w_pclr || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + DIV_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_step[i] = r_active & w_tick & lane_mask[i] & (LVL_W'(i) < r_level);

        stress_lane #(.W(LANE_WIDTH)) u_lane (
            .clk    (clk),
            .resetn (resetn),
            .step   (w_step[i]),
            .seed   (LANE_WIDTH'(SEED_BASE + i)),
            .acc    (w_acc[i])
        );
    end

    always_comb begin
        w_xor = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_xor = w_xor ^ (^w_acc[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_xor;
        end
    end

    assign out    = r_out;
    assign active = r_active;
    assign level  = r_level;

endmodule

// File: tb/tb_stress_load_gen.sv
// Bench for stress_load_gen: time-based reference model checked every cycle,
// plus directed literal expectations for the basic sequences.
module tb_stress_load_gen;

    localparam int LANES = 4;

    logic       clk = 1'b0;
    logic       resetn, enable;
    logic [1:0] mode;
    logic [7:0] div_sel, burst_on, burst_off;
    logic [3:0] lane_mask;
    logic       out, active;
    logic [2:0] level;

    stress_load_gen #(
        .LANES(LANES), .LANE_WIDTH(8), .DIV_WIDTH(8), .BURST_WIDTH(8), .SEED_BASE(1)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
        .div_sel(div_sel), .burst_on(burst_on), .burst_off(burst_off),
        .lane_mask(lane_mask), .out(out), .active(active), .level(level)
    );

    always #5 clk = ~clk;

    logic [7:0] d_acc [LANES];
    logic [7:0] d_lfsr0, d_lfsr3;
    assign d_acc[0] = dut.g_lane[0].u_lane.acc;
    assign d_acc[1] = dut.g_lane[1].u_lane.acc;
    assign d_acc[2] = dut.g_lane[2].u_lane.acc;
    assign d_acc[3] = dut.g_lane[3].u_lane.acc;
    assign d_lfsr0  = dut.g_lane[0].u_lane.r_lfsr;
    assign d_lfsr3  = dut.g_lane[3].u_lane.r_lfsr;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: m_run is the running mode (0 = idle), m_t the cycle index since entry.
    int         m_run = 0;
    int         m_t   = 0;
    logic [7:0] m_acc  [LANES];
    logic [7:0] m_lfsr [LANES];
    logic       m_out;

    function automatic int burst_pos();
        return m_t % (int'(burst_on) + int'(burst_off) + 2);
    endfunction

    function automatic logic exp_active();
        case (m_run)
            1, 3:    return 1'b1;
            2:       return burst_pos() <= int'(burst_on);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_level();
        case (m_run)
            1:       return 3'd4;
            2:       return (burst_pos() <= int'(burst_on)) ? 3'd4 : 3'd0;
            3:       return 3'((m_t / (int'(burst_on) + 1)) % LANES + 1);
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic exp_tick();
        int k;
        k = (m_run == 2) ? burst_pos() : m_t;
        return (k % (int'(div_sel) + 1)) == int'(div_sel);
    endfunction

    task automatic mdl_edge();
        logic x, act, tk;
        int   lv;
        if (!resetn) begin
            m_run = 0;
            m_t   = 0;
            m_out = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                m_acc[i]  = 8'h00;
                m_lfsr[i] = 8'(i + 1);
            end
        end else begin
            x = 1'b0;
            for (int i = 0; i < LANES; i++) x = x ^ (^m_acc[i]);
            act = exp_active();
            tk  = exp_tick();
            lv  = int'(exp_level());
            for (int i = 0; i < LANES; i++) begin
                if (act && tk && lane_mask[i] && (i < lv)) begin
                    m_acc[i]  = m_acc[i] + m_lfsr[i];
                    m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 8'hB8 : 8'h00);
                end
            end
            m_out = x;
            if (m_run == 0) begin
                if (enable && mode != 2'd0) begin
                    m_run = int'(mode);
                    m_t   = 0;
                end
            end else if (!enable || int'(mode) != m_run) begin
                m_run = 0;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic compare_cycle();
        chk("active", 64'(active), 64'(exp_active()));
        chk("level", 64'(level), 64'(exp_level()));
        chk("out", 64'(out), 64'(m_out));
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("acc%0d", i), 64'(d_acc[i]), 64'(m_acc[i]));
        end
    endtask

    always @(posedge clk) mdl_edge();
    always @(negedge clk) if (chk_en) compare_cycle();

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] pat;
    logic [7:0]  prev;
    logic [2:0]  lv_seq [9];
    logic [2:0]  lv_exp [9];
    int          nrun;

    initial begin
        lv_exp = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1};
        resetn = 1'b0; enable = 1'b0; mode = 2'd0;
        div_sel = 8'd0; burst_on = 8'd0; burst_off = 8'd0; lane_mask = 4'h0;
        step(2);
        chk_en = 1'b1;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_acc0", 64'(d_acc[0]), 64'h00);
        chk("rst_lfsr0", 64'(d_lfsr0), 64'h01);
        chk("rst_lfsr3", 64'(d_lfsr3), 64'h04);
        resetn = 1'b1;
        step(1);

        // Continuous, single lane, tick every cycle
        lane_mask = 4'b0001; div_sel = 8'd0; mode = 2'd1; enable = 1'b1;
        step(1);
        chk("cont_active", 64'(active), 64'd1);
        chk("cont_level", 64'(level), 64'd4);
        step(1);
        chk("cont_acc_t1", 64'(d_acc[0]), 64'h01);
        chk("cont_lfsr_t1", 64'(d_lfsr0), 64'hB8);
        step(1);
        chk("cont_acc_t2", 64'(d_acc[0]), 64'hB9);
        chk("cont_lfsr_t2", 64'(d_lfsr0), 64'h5C);
        step(1);
        chk("cont_acc_t3", 64'(d_acc[0]), 64'h15);
        chk("cont_lfsr_t3", 64'(d_lfsr0), 64'h2E);

        // Prescaler: div_sel=3 moves the accumulator on every 4th edge
        enable = 1'b0;
        step(1);
        chk("idle_active", 64'(active), 64'd0);
        chk("idle_pcnt", 64'(dut.r_pcnt), 64'd0);
        div_sel = 8'd3; enable = 1'b1;
        step(1);
        pat = '0;
        for (int k = 0; k < 16; k++) begin
            prev = d_acc[0];
            step(1);
            pat[k] = (d_acc[0] != prev);
        end
        chk("presc_pattern", 64'(pat), 64'h8888);
        enable = 1'b0;
        step(1);
        chk("presc_idle_pcnt", 64'(dut.r_pcnt), 64'd0);
        chk("presc_idle_active", 64'(active), 64'd0);

        // Burst: 3 cycles on, 5 cycles off
        div_sel = 8'd0; burst_on = 8'd2; burst_off = 8'd4; lane_mask = 4'hF;
        step(1);
        mode = 2'd2; enable = 1'b1;
        pat = '0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            pat[k] = active;
        end
        chk("burst_pattern", 64'(pat), 64'h0707);
        step(1);
        chk("burst_on_again", 64'(active), 64'd1);

        // Mode 2 -> 3 mid-run goes through one IDLE cycle
        mode = 2'd3;
        step(1);
        chk("m23_idle_active", 64'(active), 64'd0);
        chk("m23_idle_level", 64'(level), 64'd0);
        step(1);
        chk("m23_sweep_active", 64'(active), 64'd1);
        chk("m23_sweep_level", 64'(level), 64'd1);

        // Sweep with 2-cycle steps
        enable = 1'b0;
        step(1);
        burst_on = 8'd1; enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step(1);
            lv_seq[k] = level;
        end
        for (int k = 0; k < 9; k++) chk($sformatf("sweep_lv%0d", k), 64'(lv_seq[k]), 64'(lv_exp[k]));

        // Reset in the middle of a burst ON phase
        enable = 1'b0;
        step(1);
        mode = 2'd2; burst_on = 8'd3; burst_off = 8'd3; enable = 1'b1;
        step(3);
        chk("mid_pre_active", 64'(active), 64'd1);
        resetn = 1'b0;
        step(1);
        chk("mid_rst_active", 64'(active), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_out", 64'(out), 64'd0);
        for (int i = 0; i < LANES; i++) chk($sformatf("mid_rst_acc%0d", i), 64'(d_acc[i]), 64'd0);
        chk("mid_rst_lfsr0", 64'(d_lfsr0), 64'h01);
        resetn = 1'b1; enable = 1'b0; mode = 2'd0;
        step(1);

        // Randomized runs: parameters change only while idle
        for (int r = 0; r < 40; r++) begin
            enable = 1'b0;
            step(1 + int'($urandom_range(1, 0)));
            div_sel   = 8'($urandom_range(3, 0));
            burst_on  = 8'($urandom_range(3, 0));
            burst_off = 8'($urandom_range(3, 0));
            lane_mask = 4'($urandom);
            mode      = 2'($urandom_range(3, 1));
            enable    = 1'b1;
            nrun = int'($urandom_range(40, 5));
            for (int k = 0; k < nrun; k++) begin
                step(1);
                if ($urandom_range(11, 0) == 0) lane_mask = 4'($urandom);
                if ($urandom_range(19, 0) == 0) mode = 2'($urandom_range(3, 1));
                if ($urandom_range(39, 0) == 0) begin
                    resetn = 1'b0;
                    step(1);
                    resetn = 1'b1;
                end
            end
        end
        enable = 1'b0;
        step(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
